tnn_case_sequencer: RTL and testbench

Hardware stimulus-and-capture engine for the ternary classifiers, such as the cardio TNN (19 features × 4 bits, 40 hidden, 3 classes). It reads feature vectors and expected labels from a synchronous test-vector memory and drives each case into the classifier, holding it in a one-cycle clear beforehand. It then waits out the classifier's fixed evaluation latency, captures the prediction, scores it, and streams one result per case over a valid/ready port. It replaces the simulation-only bench loop so that self-test runs on silicon.

---
 rtl/tnn_case_sequencer.sv | 120 ++++++++++++
 tb/tb_tnn_case_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_case_sequencer.sv
// Self-test sequencer: fetch a test vector, clear and run the classifier, score and stream one result per case.
// Latency WAIT_CYCLES+4 cycles per case with res_ready high; EMIT holds every output while res_ready is low.
module tnn_case_sequencer #(
    parameter int FEAT_CNT    = 19,
    parameter int FEAT_BITS   = 4,
    parameter int HIDDEN_CNT  = 40,
    parameter int CLASS_CNT   = 3,
    parameter int TEST_CNT    = 1000,
    parameter int WAIT_CYCLES = FEAT_CNT + HIDDEN_CNT - 1,
    localparam int LBL_W      = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1,
    localparam int IDX_W      = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1,
    localparam int DAT_W      = FEAT_BITS * FEAT_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] mem_addr,
    input  logic [DAT_W-1:0] mem_data,
    input  logic [LBL_W-1:0] mem_label,
    output logic [DAT_W-1:0] dut_data,
    output logic             dut_rst,
    input  logic [LBL_W-1:0] dut_prediction,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_index,
    output logic [LBL_W-1:0] res_pred,
    output logic             res_match,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   correct_cnt
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, LOAD, CLEAR, RUN, EMIT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [LBL_W-1:0] lbl;
    logic [CNT_W-1:0] wait_cnt;
    logic             hit;

    // idx is a register, so the memory address is registered without a second copy
    assign mem_addr = idx;
    assign hit      = (dut_prediction == lbl);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            lbl         <= '0;
            wait_cnt    <= '0;
            dut_data    <= '0;
            dut_rst     <= 1'b1;
            res_valid   <= 1'b0;
            res_index   <= '0;
            res_pred    <= '0;
            res_match   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            correct_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx         <= '0;
                        correct_cnt <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    state <= LOAD;
                end
                LOAD: begin
                    dut_data <= mem_data;
                    lbl      <= mem_label;
                    state    <= CLEAR;
                end
                CLEAR: begin
                    // classifier leaves clear on this edge; the sample lands WAIT_CYCLES edges later
                    wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                    dut_rst  <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (wait_cnt == '0) begin
                        res_pred    <= dut_prediction;
                        res_match   <= hit;
                        correct_cnt <= correct_cnt + {{IDX_W{1'b0}}, hit};
                        res_index   <= idx;
                        res_valid   <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        dut_rst   <= 1'b1;
                        if (idx == IDX_W'(TEST_CNT - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ADDR;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_case_sequencer.sv
// Directed bench: a 4-case sequencer with a behavioural memory and classifier, plus a 1-case instance.
module tb_tnn_case_sequencer;

    localparam int W = 19 + 40 - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests_run = 0;
    int          tests_failed = 0;

    // 4-case instance
    logic        start = 1'b0;
    logic [1:0]  mem_addr;
    logic [75:0] mem_data = '0;
    logic [1:0]  mem_label = '0;
    logic [75:0] dut_data;
    logic        dut_rst;
    logic [1:0]  dut_prediction;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_index;
    logic [1:0]  res_pred;
    logic        res_match;
    logic        busy;
    logic        done;
    logic [2:0]  correct_cnt;

    // 1-case instance
    logic        start1 = 1'b0;
    logic [0:0]  mem_addr1;
    logic [75:0] mem_data1 = '0;
    logic [1:0]  mem_label1 = '0;
    logic [75:0] dut_data1;
    logic        dut_rst1;
    logic [1:0]  pred1;
    logic        res_valid1;
    logic        res_ready1 = 1'b1;
    logic [0:0]  res_index1;
    logic [1:0]  res_pred1;
    logic        res_match1;
    logic        busy1;
    logic        done1;
    logic [1:0]  correct_cnt1;

    logic [75:0] mem_tab [4];
    logic [1:0]  lbl_tab [4];
    logic [1:0]  good_tab [4];
    logic [75:0] data1 = 76'h1234567890ABCDEF123;
    logic [1:0]  lbl1 = 2'd2;
    logic [1:0]  good1 = 2'd2;
    int          run_cnt = 0;
    int          run_cnt1 = 0;

    always #5 clk = ~clk;

    tnn_case_sequencer #(.TEST_CNT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_label(mem_label), .dut_data(dut_data), .dut_rst(dut_rst),
        .dut_prediction(dut_prediction), .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .res_pred(res_pred), .res_match(res_match), .busy(busy),
        .done(done), .correct_cnt(correct_cnt)
    );

    tnn_case_sequencer #(.TEST_CNT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .mem_label(mem_label1), .dut_data(dut_data1), .dut_rst(dut_rst1),
        .dut_prediction(pred1), .res_valid(res_valid1), .res_ready(res_ready1),
        .res_index(res_index1), .res_pred(res_pred1), .res_match(res_match1), .busy(busy1),
        .done(done1), .correct_cnt(correct_cnt1)
    );

    // Classifier model: the correct answer is present only on the sample edge, other values before and after
    function automatic logic [1:0] model(input logic [1:0] good, input int cnt);
        int k;
        if (cnt == W - 1) k = 0;
        else if (cnt < W - 1) k = 1;
        else k = 2;
        k = (int'(good) + k) % 3;
        return k[1:0];
    endfunction

    always @(posedge clk) begin
        mem_data   <= mem_tab[mem_addr];
        mem_label  <= lbl_tab[mem_addr];
        mem_data1  <= (mem_addr1 == 1'b0) ? data1 : '0;
        mem_label1 <= lbl1;
        run_cnt    <= dut_rst ? 0 : run_cnt + 1;
        run_cnt1   <= dut_rst1 ? 0 : run_cnt1 + 1;
    end

    assign dut_prediction = model(good_tab[mem_addr], run_cnt);
    assign pred1          = model(good1, run_cnt1);

    task automatic test_reset;
        if (mem_addr !== 2'd0) begin tests_failed++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
        tests_run++;
        if (dut_data !== 76'd0) begin tests_failed++; $display("FAIL reset_dut_data got %0h want 0", dut_data); end
        tests_run++;
        if (dut_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_dut_rst got %0b want 1", dut_rst); end
        tests_run++;
        if ({res_valid, busy, done} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags valid/busy/done got %03b want 000", {res_valid, busy, done}); end
        tests_run++;
        if (correct_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_correct_cnt got %0d want 0", correct_cnt); end
        tests_run++;
    endtask

    task automatic test_single_case;
        int cyc = 1;
        int low = 0;
        logic clr_hi = 1'b0;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        while (res_valid1 !== 1'b1 && cyc < 200) begin
            if (cyc == 3) clr_hi = dut_rst1;
            if (dut_rst1 === 1'b0) low++;
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (cyc != 62) begin tests_failed++; $display("FAIL single_latency got %0d want 62", cyc); end
        tests_run++;
        if (clr_hi !== 1'b1 || low != W) begin tests_failed++; $display("FAIL single_clear clear_cycle=%0b run_cycles=%0d want 1/%0d", clr_hi, low, W); end
        tests_run++;
        if (res_pred1 !== 2'd2 || res_match1 !== 1'b1 || correct_cnt1 !== 2'd1) begin
            tests_failed++; $display("FAIL single_result pred=%0d match=%0b cnt=%0d want 2/1/1", res_pred1, res_match1, correct_cnt1);
        end
        tests_run++;
        if (dut_data1 !== 76'h1234567890ABCDEF123 || res_index1 !== 1'b0) begin
            tests_failed++; $display("FAIL single_data data=%0h idx=%0d", dut_data1, res_index1);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({done1, busy1, res_valid1, dut_rst1} !== 4'b1001) begin
            tests_failed++; $display("FAIL single_done done/busy/valid/dut_rst got %04b want 1001", {done1, busy1, res_valid1, dut_rst1});
        end
    endtask

    task automatic test_sample_edge;
        int cyc = 1;
        good1 = 2'd1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        tests_run++;
        if (done1 !== 1'b0 || correct_cnt1 !== 2'd0 || busy1 !== 1'b1) begin
            tests_failed++; $display("FAIL restart1 done=%0b cnt=%0d busy=%0b want 0/0/1", done1, correct_cnt1, busy1);
        end
        while (res_valid1 !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        tests_run++;
        if (res_pred1 !== 2'd1 || res_match1 !== 1'b0 || correct_cnt1 !== 2'd0) begin
            tests_failed++; $display("FAIL sample_edge pred=%0d match=%0b cnt=%0d want 1/0/0", res_pred1, res_match1, correct_cnt1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_scoring;
        logic [3:0] exp_match = 4'b0101;
        logic [1:0] exp_pred [4] = '{2'd0, 2'd2, 2'd2, 2'd0};
        int cyc;
        res_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc = 1;
            while (res_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            tests_run++;
            if (cyc != 62) begin tests_failed++; $display("FAIL score_spacing case %0d got %0d want 62", i, cyc); end
            tests_run++;
            if (res_index !== 2'(i) || res_pred !== exp_pred[i] || res_match !== exp_match[i]) begin
                tests_failed++; $display("FAIL score_case %0d idx=%0d pred=%0d match=%0b want %0d/%0d/%0b",
                                         i, res_index, res_pred, res_match, i, exp_pred[i], exp_match[i]);
            end
            tests_run++;
            if (dut_data !== mem_tab[i]) begin tests_failed++; $display("FAIL score_data case %0d got %0h want %0h", i, dut_data, mem_tab[i]); end
            @(posedge clk); #1;
        end
        tests_run++;
        if (correct_cnt !== 3'd2 || done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL score_done cnt=%0d done=%0b busy=%0b want 2/1/0", correct_cnt, done, busy);
        end
    endtask

    task automatic test_backpressure;
        int cyc = 1;
        logic ok;
        res_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        tests_run++;
        if (mem_addr !== 2'd0 || done !== 1'b0 || correct_cnt !== 3'd0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL restart addr=%0d done=%0b cnt=%0d busy=%0b want 0/0/0/1", mem_addr, done, correct_cnt, busy);
        end
        while (res_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        for (int k = 0; k < 10; k++) begin
            ok = (res_valid === 1'b1) && (res_index === 2'd0) && (res_pred === 2'd0) && (res_match === 1'b1) &&
                 (dut_data === mem_tab[0]) && (mem_addr === 2'd0) && (correct_cnt === 3'd1) && (busy === 1'b1);
            tests_run++;
            if (!ok) begin
                tests_failed++; $display("FAIL stall_hold cycle %0d valid=%0b idx=%0d pred=%0d match=%0b addr=%0d cnt=%0d",
                                         k, res_valid, res_index, res_pred, res_match, mem_addr, correct_cnt);
            end
            if (k == 5) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (res_valid !== 1'b0 || mem_addr !== 2'd1 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL stall_release valid=%0b addr=%0d busy=%0b want 0/1/1", res_valid, mem_addr, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int n = 0;
        int cyc = 1;
        while (mem_addr !== 2'd3 && n < 400) begin @(posedge clk); #1; n++; end
        repeat (29) begin @(posedge clk); #1; end
        tests_run++;
        if (dut_rst !== 1'b0 || correct_cnt !== 3'd2 || res_index !== 2'd2) begin
            tests_failed++; $display("FAIL pre_abort dut_rst=%0b cnt=%0d idx=%0d want 0/2/2", dut_rst, correct_cnt, res_index);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({res_valid, busy, done, res_match, dut_rst} !== 5'b00001 || mem_addr !== 2'd0) begin
            tests_failed++; $display("FAIL abort_flags valid/busy/done/match/dut_rst=%05b addr=%0d", {res_valid, busy, done, res_match, dut_rst}, mem_addr);
        end
        tests_run++;
        if (res_index !== 2'd0 || res_pred !== 2'd0 || correct_cnt !== 3'd0 || dut_data !== 76'd0) begin
            tests_failed++; $display("FAIL abort_values idx=%0d pred=%0d cnt=%0d data=%0h want zeros", res_index, res_pred, correct_cnt, dut_data);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        tests_run++;
        if (mem_addr !== 2'd0 || correct_cnt !== 3'd0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL rerun_start addr=%0d cnt=%0d busy=%0b want 0/0/1", mem_addr, correct_cnt, busy);
        end
        while (res_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        tests_run++;
        if (cyc != 62 || res_index !== 2'd0 || correct_cnt !== 3'd1) begin
            tests_failed++; $display("FAIL rerun_first cyc=%0d idx=%0d cnt=%0d want 62/0/1", cyc, res_index, correct_cnt);
        end
    endtask

    initial begin
        mem_tab[0] = 76'h1234567890ABCDEF123;
        mem_tab[1] = 76'hFEDCBA9876543210ABC;
        mem_tab[2] = 76'h0F0F0F0F0F0F0F0F0F0;
        mem_tab[3] = 76'hA5A5A5A5A5A5A5A5A5A;
        lbl_tab[0] = 2'd0; lbl_tab[1] = 2'd1; lbl_tab[2] = 2'd2; lbl_tab[3] = 2'd1;
        good_tab[0] = 2'd0; good_tab[1] = 2'd2; good_tab[2] = 2'd2; good_tab[3] = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_single_case();
        test_sample_edge();
        test_scoring();
        test_backpressure();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
